// File: rtl/game_ctrl_pkg.sv
// Shared types and widths for the SkyHop game sequencer.
package game_ctrl_pkg;

  localparam int SCORE_W = 12;
  localparam int TIME_W  = 8;

  // GS_BAD is unreachable in normal operation and recovers to IDLE.
  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_END  = 2'd2,
    GS_BAD  = 2'd3
  } game_state_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Player-input and overlay-output bundle between the game sequencer and its surroundings.
interface game_ctrl_if;
  import game_ctrl_pkg::*;

  logic               key_space;
  logic               jump_ok;
  logic               jump_fail_in;
  logic               start_en;
  logic               game_en;
  logic               end_en;
  logic [SCORE_W-1:0] score;
  logic [TIME_W-1:0]  time_left;
  logic               fail_flag;
  logic               one_sec_tick;

  modport master (
    output key_space, jump_ok, jump_fail_in,
    input  start_en, game_en, end_en, score, time_left, fail_flag, one_sec_tick
  );

  modport slave (
    input  key_space, jump_ok, jump_fail_in,
    output start_en, game_en, end_en, score, time_left, fail_flag, one_sec_tick
  );

endinterface

// File: rtl/game_ctrl_sec_tick_gen.sv
// Free-running divider: one registered 1-cycle tick every CLK_HZ clocks.
module sec_tick_gen #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Tick is raised on the cycle after the counter reads LAST, so the first
  // one lands exactly CLK_HZ cycles after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/game_ctrl.sv
// SkyHop game sequencer: start screen -> play -> end screen, with BCD score,
// BCD countdown and a post-game key lockout.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 65_000_000,
  parameter int GAME_TIME_S = 60,
  parameter int LOCKOUT_S   = 2
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  localparam logic [TIME_W-1:0] TIME_INIT = {4'(GAME_TIME_S / 10), 4'(GAME_TIME_S % 10)};
  localparam int                LW        = (LOCKOUT_S > 0) ? $clog2(LOCKOUT_S + 1) : 1;

  function automatic logic [SCORE_W-1:0] bcd3_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [TIME_W-1:0] bcd2_dec(input logic [TIME_W-1:0] v);
    logic [TIME_W-1:0] r;
    r = v;
    if (v != 8'h00) begin
      if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
      else                r = {v[7:4] - 4'd1, 4'd9};
    end
    return r;
  endfunction

  logic               w_tick;
  logic               w_to_end;
  game_state_t        r_state;
  logic               r_start_en;
  logic               r_game_en;
  logic               r_end_en;
  logic [SCORE_W-1:0] r_score;
  logic [TIME_W-1:0]  r_time;
  logic               r_fail;
  logic [LW-1:0]      r_lockout;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // A fall and a timeout on the same edge both land in END; only the fall sets fail.
  assign w_to_end = bus.jump_fail_in || (w_tick && (r_time == 8'h01));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= GS_IDLE;
      r_start_en <= 1'b1;
      r_game_en  <= 1'b0;
      r_end_en   <= 1'b0;
      r_score    <= '0;
      r_time     <= TIME_INIT;
      r_fail     <= 1'b0;
      r_lockout  <= '0;
    end else begin
      case (r_state)
        GS_IDLE: begin
          if (bus.key_space) begin
            r_state    <= GS_PLAY;
            r_start_en <= 1'b0;
            r_game_en  <= 1'b1;
            r_score    <= '0;
            r_time     <= TIME_INIT;
            r_fail     <= 1'b0;
          end
        end
        GS_PLAY: begin
          if (w_tick) r_time <= bcd2_dec(r_time);
          if (bus.jump_fail_in)  r_fail  <= 1'b1;
          else if (bus.jump_ok)  r_score <= bcd3_inc(r_score);
          if (w_to_end) begin
            r_state   <= GS_END;
            r_game_en <= 1'b0;
            r_end_en  <= 1'b1;
            r_lockout <= LW'(LOCKOUT_S);
          end
        end
        GS_END: begin
          if (bus.key_space && (r_lockout == '0)) begin
            r_state    <= GS_IDLE;
            r_end_en   <= 1'b0;
            r_start_en <= 1'b1;
          end else if (w_tick && (r_lockout != '0)) begin
            r_lockout <= r_lockout - 1'b1;
          end
        end
        default: begin
          r_state    <= GS_IDLE;
          r_start_en <= 1'b1;
          r_game_en  <= 1'b0;
          r_end_en   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_en     = r_start_en;
  assign bus.game_en      = r_game_en;
  assign bus.end_en       = r_end_en;
  assign bus.score        = r_score;
  assign bus.time_left    = r_time;
  assign bus.fail_flag    = r_fail;
  assign bus.one_sec_tick = w_tick;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed + randomized bench for game_ctrl against an integer-valued game model.
module tb_game_ctrl;
  import game_ctrl_pkg::*;

  localparam int HZ   = 10;
  localparam int GT   = 3;
  localparam int LK   = 1;
  localparam int HZ_B = 1200;
  localparam int GT_B = 2;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_END  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_ctrl_if bus_a ();
  game_ctrl_if bus_b ();

  game_ctrl #(.CLK_HZ(HZ), .GAME_TIME_S(GT), .LOCKOUT_S(LK)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  game_ctrl #(.CLK_HZ(HZ_B), .GAME_TIME_S(GT_B), .LOCKOUT_S(1)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Game model in plain decimal integers.
  int m_mode, m_score, m_time, m_lock, m_cnt;
  bit m_tick, m_fail;

  function automatic logic [11:0] bcd3(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit ks, input bit ok, input bit fl, input bit rs);
    bit tick_now;
    int t_old;
    if (rs) begin
      m_mode = M_IDLE; m_score = 0; m_time = GT; m_fail = 0;
      m_tick = 0; m_cnt = 0; m_lock = 0;
      return;
    end
    tick_now = m_tick;
    t_old    = m_time;
    m_tick   = (m_cnt == HZ - 1);
    m_cnt    = (m_cnt == HZ - 1) ? 0 : m_cnt + 1;
    case (m_mode)
      M_IDLE: if (ks) begin
        m_mode = M_PLAY; m_score = 0; m_time = GT; m_fail = 0;
      end
      M_PLAY: begin
        if (tick_now) m_time = m_time - 1;
        if (fl) begin
          m_fail = 1; m_mode = M_END; m_lock = LK;
        end else if (ok) begin
          m_score = (m_score < 999) ? m_score + 1 : 999;
        end
        if (tick_now && t_old == 1) begin
          m_mode = M_END; m_lock = LK;
        end
      end
      default: begin
        if (ks && m_lock == 0) m_mode = M_IDLE;
        else if (tick_now && m_lock > 0) m_lock = m_lock - 1;
      end
    endcase
  endtask

  task automatic check_model();
    chk("start_en",     bus_a.start_en,     m_mode == M_IDLE);
    chk("game_en",      bus_a.game_en,      m_mode == M_PLAY);
    chk("end_en",       bus_a.end_en,       m_mode == M_END);
    chk("score",        bus_a.score,        bcd3(m_score));
    chk("time_left",    bus_a.time_left,    bcd2(m_time));
    chk("fail_flag",    bus_a.fail_flag,    m_fail);
    chk("one_sec_tick", bus_a.one_sec_tick, m_tick);
  endtask

  task automatic step(input bit ks, input bit ok, input bit fl, input bit rs);
    bus_a.key_space    = ks;
    bus_a.jump_ok      = ok;
    bus_a.jump_fail_in = fl;
    rst                = rs;
    @(posedge clk);
    model_update(ks, ok, fl, rs);
    @(negedge clk);
    check_model();
    bus_a.key_space    = 1'b0;
    bus_a.jump_ok      = 1'b0;
    bus_a.jump_fail_in = 1'b0;
    bus_b.key_space    = 1'b0;
    bus_b.jump_ok      = 1'b0;
    bus_b.jump_fail_in = 1'b0;
    rst                = 1'b0;
  endtask

  task automatic wait_lock_clear(input string tag);
    int n;
    n = 0;
    while (m_lock != 0 && n < 40) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk(tag, (n < 40), 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      assert ($onehot({bus_a.start_en, bus_a.game_en, bus_a.end_en})) else begin
        errors++;
        $error("FAIL onehot_enables observed=%b expected=one-hot",
               {bus_a.start_en, bus_a.game_en, bus_a.end_en});
      end
    end
  end

  initial begin
    int first;
    int n;
    bus_a.key_space = 0; bus_a.jump_ok = 0; bus_a.jump_fail_in = 0;
    bus_b.key_space = 0; bus_b.jump_ok = 0; bus_b.jump_fail_in = 0;

    // Reset and first tick position
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_time", bus_a.time_left, 8'h03);
    mon_on = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 1'($urandom % 2), 1'($urandom % 2), 0);
      if (bus_a.one_sec_tick && first < 0) first = i + 1;
    end
    chk("first_tick_cycle", first, 10);

    // Start and score
    step(1, 0, 0, 0);
    chk("start_game_en", bus_a.game_en, 1'b1);
    repeat (12) step(0, 1, 0, 0);
    chk("score_after_12", bus_a.score, 12'h012);

    // Timeout
    n = 0;
    while (!bus_a.end_en && n < 40) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk("timeout_end_en", bus_a.end_en, 1'b1);
    chk("timeout_fail", bus_a.fail_flag, 1'b0);
    chk("timeout_time", bus_a.time_left, 8'h00);
    chk("timeout_score", bus_a.score, 12'h012);

    // Lockout then restart
    step(1, 0, 0, 0);
    chk("lockout_ignore", bus_a.end_en, 1'b1);
    wait_lock_clear("lockout_clear_1");
    step(1, 0, 0, 0);
    chk("back_to_idle", bus_a.start_en, 1'b1);
    chk("idle_score_held", bus_a.score, 12'h012);
    step(1, 0, 0, 0);
    chk("restart_score", bus_a.score, 12'h000);

    // Fall with simultaneous jump_ok
    repeat (5) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("fall_end_en", bus_a.end_en, 1'b1);
    chk("fall_fail", bus_a.fail_flag, 1'b1);
    chk("fall_score", bus_a.score, 12'h005);

    step(1, 0, 0, 0);
    chk("lockout_ignore_2", bus_a.end_en, 1'b1);
    wait_lock_clear("lockout_clear_2");
    step(1, 0, 0, 0);
    chk("idle_score_005", bus_a.score, 12'h005);
    step(1, 0, 0, 0);
    chk("play_score_000", bus_a.score, 12'h000);

    // Mid-play reset
    repeat (7) step(0, 1, 0, 0);
    chk("pre_reset_score", bus_a.score, 12'h007);
    step(0, 0, 0, 1);
    chk("rst_start_en", bus_a.start_en, 1'b1);
    chk("rst_game_en", bus_a.game_en, 1'b0);
    chk("rst_score", bus_a.score, 12'h000);
    chk("rst_time", bus_a.time_left, 8'h03);
    chk("rst_fail", bus_a.fail_flag, 1'b0);
    chk("rst_tick", bus_a.one_sec_tick, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom % 4 == 0), 1'($urandom % 2), 1'($urandom % 16 == 0),
           1'($urandom % 300 == 0));
    end

    // Score carry and saturation on the long-game instance
    step(0, 0, 0, 1);
    bus_b.key_space = 1'b1;
    step(0, 0, 0, 0);
    chk("sat_game_en", bus_b.game_en, 1'b1);
    for (int k = 1; k <= 1005; k++) begin
      bus_b.jump_ok = 1'b1;
      step(0, 0, 0, 0);
      if (k == 9 || k == 99 || k == 100 || k == 999 || k == 1000 || k == 1005)
        chk($sformatf("sat_score_%0d", k), bus_b.score, bcd3((k < 999) ? k : 999));
    end
    chk("sat_still_play", bus_b.game_en, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
